// File: rtl/alu_writeback.sv
// alu_writeback: execution and write-back stage behind the 16x8 register file.
// Computes an 8-bit ALU result or an 8-cycle shift-add 8x8 multiply, then
// drives the file's Di/Xh/SRD/LE with the two-cycle write timing it needs.
// The file registers LE/SRD on one edge and loads Di on the next.
// Optional macro ALU_CARRY_OPS_EN enables ADC (0xA) and SBC (0xB).
// When the macro is undefined, opcodes 0xA and 0xB behave as NOP.
module alu_writeback #(
    parameter int         W       = 8,
    parameter logic [3:0] XH_IDX  = 4'd14,
    parameter logic [3:0] XL_IDX  = 4'd15,
    parameter logic [3:0] PIN_IDX = 4'd10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [3:0]   dst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    input  logic         use_imm,
    output logic [W-1:0] di,
    output logic [W-1:0] xh,
    output logic [3:0]   srd,
    output logic         le,
    output logic         busy,
    output logic         done,
    output logic [3:0]   flags
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_WB, S_HOLD, S_WB2, S_HOLD2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             mul_q, mul_d;
    logic [W-1:0]     di_q, di_d, xh_q, xh_d;
    logic [3:0]       srd_q, srd_d;
    logic             le_q, le_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]       flags_q, flags_d;

    logic [W-1:0]     b_op, alu_res;
    logic [W:0]       alu_sum;
    logic             alu_ok, alu_c, alu_v, cin, is_mul, protect;
    logic [2*W-1:0]   mul_add, prod_nxt;

    // Single-cycle ALU result and flags from the live operands at the accept edge.
    always_comb begin
        b_op    = use_imm ? imm : b;
        cin     = flags_q[2];
        alu_ok  = 1'b1;
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            4'h0: begin
                alu_sum = {1'b0, a} + {1'b0, b_op};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_v   = (a[W-1] == b_op[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            4'h1: begin
                alu_sum = {1'b0, a} - {1'b0, b_op};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_v   = (a[W-1] != b_op[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            4'h2: alu_res = a & b_op;
            4'h3: alu_res = a | b_op;
            4'h4: alu_res = a ^ b_op;
            4'h5: alu_res = ~a;
            4'h6: begin
                alu_res = {a[W-2:0], 1'b0};
                alu_c   = a[W-1];
            end
            4'h7: begin
                alu_res = {1'b0, a[W-1:1]};
                alu_c   = a[0];
            end
            4'h8: alu_res = b_op;
`ifdef ALU_CARRY_OPS_EN
            4'hA: begin
                alu_sum = {1'b0, a} + {1'b0, b_op} + {{W{1'b0}}, cin};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_v   = (a[W-1] == b_op[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            4'hB: begin
                // 9-bit wrap leaves the borrow in the top bit.
                alu_sum = {1'b0, a} - {1'b0, b_op} - {{W{1'b0}}, cin};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
                alu_v   = (a[W-1] != b_op[W-1]) && (alu_res[W-1] != a[W-1]);
            end
`endif
            default: alu_ok = 1'b0;
        endcase
        is_mul  = (op == 4'h9);
        protect = (dst == PIN_IDX) || (dst == XH_IDX);
    end

    // One shift-add step per MUL cycle; cnt_q selects the multiplier bit.
    always_comb begin
        mul_add  = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
        prod_nxt = prod_q + mul_add;
    end

    // Sequencer next-state: le and done default low so each is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mul_d   = mul_q;
        di_d    = di_q;
        xh_d    = xh_q;
        srd_d   = srd_q;
        le_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    mul_d  = is_mul;
                    if (is_mul) begin
                        state_d = S_MUL;
                        a_d     = a;
                        b_d     = b_op;
                        cnt_d   = '0;
                        prod_d  = '0;
                    end else if (alu_ok) begin
                        state_d = S_WB;
                        di_d    = alu_res;
                        srd_d   = dst;
                        le_d    = !protect;
                        flags_d = {alu_res == '0, alu_c, alu_res[W-1], alu_v};
                    end else begin
                        state_d = S_HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d = prod_nxt;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_WB;
                    le_d    = 1'b1;
                    srd_d   = XL_IDX;
                    di_d    = prod_nxt[W-1:0];
                    xh_d    = prod_nxt[2*W-1:W];
                    flags_d = {prod_nxt == '0, prod_nxt[2*W-1:W] != '0, 2'b00};
                end
            end
            S_WB: begin
                state_d = S_HOLD;
                done_d  = !mul_q;
            end
            S_HOLD: begin
                if (mul_q) begin
                    // Second write: the file takes the high byte from Xh.
                    state_d = S_WB2;
                    le_d    = 1'b1;
                    srd_d   = XH_IDX;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_WB2: begin
                state_d = S_HOLD2;
                done_d  = 1'b1;
            end
            S_HOLD2: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mul_q   <= 1'b0;
            di_q    <= '0;
            xh_q    <= '0;
            srd_q   <= '0;
            le_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mul_q   <= mul_d;
            di_q    <= di_d;
            xh_q    <= xh_d;
            srd_q   <= srd_d;
            le_q    <= le_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end

    assign di    = di_q;
    assign xh    = xh_q;
    assign srd   = srd_q;
    assign le    = le_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: a directed vector table, hand sequences for MUL, reset
// and the carry ops, and random operations checked against an arithmetic model.
module tb_alu_writeback;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, use_imm = 1'b0;
    logic [3:0] op = '0, dst = '0;
    logic [7:0] a = '0, b = '0, imm = '0;
    logic [7:0] di, xh;
    logic [3:0] srd, flags;
    logic       le, busy, done;

    alu_writeback dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
        .a(a), .b(b), .imm(imm), .use_imm(use_imm),
        .di(di), .xh(xh), .srd(srd), .le(le), .busy(busy), .done(done), .flags(flags)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0;
    string      cur_tag = "";
    logic [3:0] m_flags = '0;

    // Observations from one operation (cycle 1 = first cycle after the accept edge).
    int         o_done_cyc, o_done_n, o_le_n, o_busy_bad, o_stable_err, o_stray, o_timeout;
    int         o_le_cyc[2];
    logic [3:0] o_le_srd[2];
    logic [7:0] o_le_di[2];
    logic [7:0] o_xh;
    logic [3:0] o_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0h expected %0h", cur_tag, name, act, exp);
        end
    endtask

    // Issue one operation and watch the bus until a few cycles after busy drops.
    task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] iv, input logic ui, input logic [3:0] d,
                          input bit spam);
        logic       prev_le;
        logic [7:0] prev_di;
        op = o; a = av; b = bv; imm = iv; use_imm = ui; dst = d; start = 1'b1;
        o_done_cyc = -1; o_done_n = 0; o_le_n = 0; o_busy_bad = 0; o_stable_err = 0;
        o_stray = 0; o_timeout = 1; o_xh = '0; o_flags = '0;
        prev_le = 1'b0; prev_di = '0;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (prev_le && (di !== prev_di || le)) o_stable_err++;
            if (le) begin
                if (o_le_n < 2) begin
                    o_le_cyc[o_le_n] = k; o_le_srd[o_le_n] = srd; o_le_di[o_le_n] = di;
                end
                o_le_n++;
                o_xh = xh;
            end
            prev_le = le; prev_di = di;
            if (done) begin
                o_done_n++;
                if (o_done_cyc < 0) begin o_done_cyc = k; o_flags = flags; end
            end
            if (o_done_cyc < 0 || k == o_done_cyc) begin
                if (!busy) o_busy_bad++;
            end else if (k == o_done_cyc + 1) begin
                if (busy) o_busy_bad++;
                o_timeout = 0;
            end else begin
                if (le || done || busy) o_stray++;
                if (k >= o_done_cyc + 3) break;
            end
            start = spam && (o_done_cyc < 0);
        end
        start = 1'b0;
        chk("completed", o_timeout, 0);
    endtask

    // Reference arithmetic on plain integers: kind 0=NOP, 1=ALU, 2=MUL.
    task automatic model(input logic [3:0] o, input int av, input int bv, input int c_in,
                         output int kind, output int res, output logic [3:0] fl, output int hi);
        int s, sa, sb, sr;
        bit c, v;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        kind = 1; c = 0; v = 0; hi = 0; s = 0; sr = 0;
        case (o)
            4'h0: begin s = av + bv; c = (s > 255); sr = sa + sb; end
            4'h1: begin s = av - bv; c = (s < 0);   sr = sa - sb; end
            4'h2: s = av & bv;
            4'h3: s = av | bv;
            4'h4: s = av ^ bv;
            4'h5: s = 255 - av;
            4'h6: begin s = av * 2; c = (av >= 128); end
            4'h7: begin s = av / 2; c = (av % 2 == 1); end
            4'h8: s = bv;
            4'h9: begin kind = 2; s = av * bv; end
`ifdef ALU_CARRY_OPS_EN
            4'hA: begin s = av + bv + c_in; c = (s > 255); sr = sa + sb + c_in; end
            4'hB: begin s = av - bv - c_in; c = (s < 0);   sr = sa - sb - c_in; end
`endif
            default: kind = 0;
        endcase
        if (o <= 4'h1 || o == 4'hA || o == 4'hB) v = (sr > 127) || (sr < -128);
        if (kind == 2) begin
            res = s % 256; hi = s / 256;
            fl  = {s == 0, hi != 0, 2'b00};
        end else begin
            res = s & 255;
            fl  = {res == 0, c, res >= 128, v};
        end
    endtask

    task automatic check_vs_model(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bop,
                                  input logic [3:0] d);
        int kind, res, hi, exp_le;
        logic [3:0] fl;
        bit prot;
        model(o, int'(av), int'(bop), int'(m_flags[2]), kind, res, fl, hi);
        prot   = (d == 4'd10) || (d == 4'd14);
        exp_le = (kind == 0) ? 0 : (kind == 2) ? 2 : (prot ? 0 : 1);
        chk("done_cycle", o_done_cyc, (kind == 0) ? 1 : (kind == 1) ? 2 : 12);
        chk("le_count", o_le_n, exp_le);
        if (kind == 1 && !prot) begin
            chk("le_cycle", o_le_cyc[0], 1);
            chk("srd", o_le_srd[0], d);
            chk("di", o_le_di[0], res);
        end
        if (kind == 2 && o_le_n == 2) begin
            chk("mul_lo_cycle", o_le_cyc[0], 9);
            chk("mul_lo_srd", o_le_srd[0], 15);
            chk("mul_lo_di", o_le_di[0], res);
            chk("mul_hi_cycle", o_le_cyc[1], 11);
            chk("mul_hi_srd", o_le_srd[1], 14);
            chk("mul_xh", o_xh, hi);
        end
        if (kind != 0) m_flags = fl;
        chk("flags", o_flags, m_flags);
        chk("protocol", o_busy_bad + o_stable_err + o_stray + o_done_n - 1, 0);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, imm;
        logic       ui;
        logic [3:0] dst;
        logic [7:0] di;
        logic [3:0] fl;
        int         nle;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstray;
        logic [3:0] ro, rd;
        logic [7:0] ra, rb, ri;
        logic       ru;

        tbl[0]  = '{4'h0, 8'h7F, 8'h01, 8'h00, 1'b0, 4'd3,  8'h80, 4'b0011, 1};
        tbl[1]  = '{4'h1, 8'h05, 8'hAA, 8'h05, 1'b1, 4'd2,  8'h00, 4'b1000, 1};
        tbl[2]  = '{4'h1, 8'h01, 8'h02, 8'h00, 1'b0, 4'd2,  8'hFF, 4'b0110, 1};
        tbl[3]  = '{4'h2, 8'hF0, 8'h3C, 8'h00, 1'b0, 4'd1,  8'h30, 4'b0000, 1};
        tbl[4]  = '{4'h3, 8'h0F, 8'hF0, 8'h00, 1'b0, 4'd4,  8'hFF, 4'b0010, 1};
        tbl[5]  = '{4'h4, 8'hAA, 8'hAA, 8'h00, 1'b0, 4'd5,  8'h00, 4'b1000, 1};
        tbl[6]  = '{4'h5, 8'h0F, 8'h00, 8'h00, 1'b0, 4'd6,  8'hF0, 4'b0010, 1};
        tbl[7]  = '{4'h6, 8'h81, 8'h00, 8'h00, 1'b0, 4'd7,  8'h02, 4'b0100, 1};
        tbl[8]  = '{4'h7, 8'h01, 8'h00, 8'h00, 1'b0, 4'd8,  8'h00, 4'b1100, 1};
        tbl[9]  = '{4'h8, 8'h00, 8'h00, 8'h55, 1'b1, 4'd10, 8'h55, 4'b0000, 0};
        tbl[10] = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b0, 4'd9,  8'h00, 4'b1100, 1};
        tbl[11] = '{4'h0, 8'h80, 8'h80, 8'h00, 1'b0, 4'd0,  8'h00, 4'b1101, 1};
        tbl[12] = '{4'h8, 8'h00, 8'h80, 8'h00, 1'b0, 4'd14, 8'h80, 4'b0010, 0};
        tbl[13] = '{4'h1, 8'h80, 8'h01, 8'h00, 1'b0, 4'd11, 8'h7F, 4'b0001, 1};

        // Reset state
        cur_tag = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("outputs", {le, busy, done, di, xh, srd, flags}, 0);
        rst = 1'b0;

        // Directed vectors; the store to PIN_IDX also pulses start while busy.
        foreach (tbl[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].ui, tbl[i].dst,
                   tbl[i].dst == 4'd10);
            chk("done_cycle", o_done_cyc, 2);
            chk("le_count", o_le_n, tbl[i].nle);
            if (o_le_n == 1 && tbl[i].nle == 1) begin
                chk("srd", o_le_srd[0], tbl[i].dst);
                chk("di", o_le_di[0], tbl[i].di);
            end
            chk("flags", o_flags, tbl[i].fl);
            chk("protocol", o_busy_bad + o_stable_err + o_stray + o_done_n - 1, 0);
            m_flags = tbl[i].fl;
        end

        // MUL 0xFF * 0xFF = 0xFE01
        cur_tag = "mul_ff";
        run_op(4'h9, 8'hFF, 8'hFF, 8'h00, 1'b0, 4'd5, 1'b0);
        chk("done_cycle", o_done_cyc, 12);
        chk("le_count", o_le_n, 2);
        chk("lo_write", {o_le_cyc[0][7:0], o_le_srd[0], o_le_di[0]}, {8'd9, 4'd15, 8'h01});
        chk("hi_write", {o_le_cyc[1][7:0], o_le_srd[1], o_xh}, {8'd11, 4'd14, 8'hFE});
        chk("flags", o_flags, 4'b0100);
        chk("protocol", o_busy_bad + o_stable_err + o_stray + o_done_n - 1, 0);
        m_flags = 4'b0100;

        // Carry-in ops after SHL sets C
        cur_tag = "shl_c";
        run_op(4'h6, 8'h80, 8'h00, 8'h00, 1'b0, 4'd1, 1'b0);
        chk("di", o_le_di[0], 8'h00);
        chk("flags", o_flags, 4'b1100);
        m_flags = 4'b1100;
        cur_tag = "adc";
        run_op(4'hA, 8'h10, 8'h20, 8'h00, 1'b0, 4'd2, 1'b0);
`ifdef ALU_CARRY_OPS_EN
        chk("done_cycle", o_done_cyc, 2);
        chk("le_count", o_le_n, 1);
        chk("di", o_le_di[0], 8'h31);
        chk("flags", o_flags, 4'b0000);
        m_flags = 4'b0000;
`else
        chk("done_cycle", o_done_cyc, 1);
        chk("le_count", o_le_n, 0);
        chk("flags", o_flags, 4'b1100);
`endif

        // Randomized operations against the model
        for (int n = 0; n < 80; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom); rb = 8'($urandom); ri = 8'($urandom);
            ru = 1'($urandom); rd = 4'($urandom);
            cur_tag = $sformatf("rand%0d_op%0h", n, ro);
            run_op(ro, ra, rb, ri, ru, rd, 1'($urandom));
            check_vs_model(ro, ra, ru ? ri : rb, rd);
        end

        // Reset for two cycles in the middle of a MUL
        cur_tag = "rst_mid_mul";
        op = 4'h9; a = 8'hC3; b = 8'h5A; use_imm = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("outputs", {le, busy, done, di, xh, srd, flags}, 0);
        @(negedge clk);
        rst = 1'b0;
        nstray = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (le || done || busy) nstray++;
        end
        chk("no_late_write", nstray, 0);
        m_flags = '0;

        // Recovery after abort
        cur_tag = "post_rst";
        run_op(4'h0, 8'h22, 8'h11, 8'h00, 1'b0, 4'd7, 1'b0);
        check_vs_model(4'h0, 8'h22, 8'h11, 4'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execution and write-back stage downstream of the 16x8 register file.
- Consumes the file's two read ports (OutA/OutB) and computes an 8-bit ALU result or a multi-cycle 8x8 multiply.
- Drives the file's write side: Di, Xh, SRD, LE.
- Generates the two-cycle write-back timing the file requires: the file registers LE/SRD at one edge and loads Di at the next.

Parameters:
- W, 8, datapath width; only 8 is supported.
- XH_IDX, 14, register index loaded from the Xh port; receives the MUL high byte.
- XL_IDX, 15, register index that receives the MUL low byte.
- PIN_IDX, 10, input-port register index; not writable from Di.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  issue request; sampled only in IDLE.
- op  in  4  opcode, latched on accept.
- dst  in  4  destination register, latched on accept; ignored for MUL.
- a  in  8  operand A, from register-file OutA.
- b  in  8  operand B, from register-file OutB.
- imm  in  8  immediate operand.
- use_imm  in  1  1: B operand is imm; 0: B operand is b.
- di  out  8  write data to register-file Di.
- xh  out  8  MUL high byte to register-file Xh.
- srd  out  4  write select to register-file SRD.
- le  out  1  write enable to register-file LE.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.
- flags  out  4  {Z,C,N,V}, registered.

Behaviour:
- Reset: state=IDLE; di, xh, srd, flags = 0; le, busy, done = 0.
  - rst mid-operation aborts on that edge.
  - le=0 from the next cycle; no partial write is issued; the product is discarded.
- Accept: at an edge where state=IDLE and start=1, latch op, dst, a, and B=(use_imm?imm:b).
  - start is ignored while busy=1; no queueing.
- Opcodes:
  - 0 ADD, 1 SUB (a-B), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a, 8 MOV B, 9 MUL.
  - A ADC and B SBC: see Optional Feature.
  - C-F NOP.
- Arithmetic and flags:
  - All results are mod 256.
  - ADD: C = carry out.
  - SUB: C = borrow (a<B unsigned).
  - V = signed overflow for ADD/SUB; V=0 for other ops.
  - SHL: C=a[7]. SHR: C=a[0] (logical shift, zero fill).
  - Logic ops and MOV: C=0.
  - Z = (result==0); N = result[7].
  - Flags register on the edge entering WB.
- Single-cycle ops (states IDLE -> WB -> HOLD -> IDLE):
  - Edge E0 accepts. di <= result, srd <= dst.
  - Cycle after E0 (WB): le=1, busy=1.
  - Cycle after E1 (HOLD): le=0, di and srd held, done=1.
  - After E2: IDLE, busy=0. Issue-to-done latency is 2 cycles.
  - Back-to-back: start high during HOLD is ignored; the next accept is at the IDLE edge.
- Protected destinations: if dst==PIN_IDX or dst==XH_IDX for a non-MUL op, le stays 0 in WB. Flags update and done pulses as normal.
- MUL (IDLE -> MUL x8 -> WB -> HOLD -> WB2 -> HOLD2 -> IDLE):
  - Unsigned shift-add over 8 cycles with a 3-bit counter from 0 to 7.
  - WB: le=1, srd=XL_IDX, di=product[7:0]; xh=product[15:8] from this cycle until the next accept.
  - HOLD: le=0, di held.
  - WB2: le=1, srd=XH_IDX.
  - HOLD2: done=1.
  - Issue-to-done latency is 12 cycles.
  - Flags: Z=(product==0), C=(product[15:8]!=0), N=V=0.
- NOP: IDLE -> HOLD; done one cycle after accept, le never asserted, flags unchanged.
- le is never asserted in two consecutive cycles. di is stable for the LE cycle and the cycle after.

Optional Feature:
- Macro: ALU_CARRY_OPS_EN.
- Defined:
  - ADC (A) = a + B + C.
  - SBC (B) = a - B - C, where C is the stored flag before the op; C out is the borrow.
  - Both use single-cycle timing and standard flag rules.
- Undefined: opcodes A and B behave as NOP.

Test Plan:
- rst=1 for 2 cycles during a MUL -> le=0 from the next cycle; all outputs 0; busy=0.
- ADD a=8'h7F, B=8'h01, dst=3 -> WB cycle le=1, srd=3, di=8'h80; next cycle done=1, flags Z=0 C=0 N=1 V=1.
- SUB a=8'h05, use_imm=1, imm=8'h05, dst=2 -> di=8'h00, Z=1, C=0; then SUB a=8'h01, B=8'h02 -> di=8'hFF, C=1, N=1.
- MUL a=8'hFF, B=8'hFF -> le pulses with srd=15 di=8'h01, then srd=14 with xh=8'hFE; done 12 cycles after accept; C=1.
- MOV B=8'h55, dst=10 -> le never asserted; done pulses; Z=0. A start pulse during busy is ignored: no second done.
- With ALU_CARRY_OPS_EN: SHL a=8'h80 (C=1), then ADC a=8'h10, B=8'h20 -> di=8'h31. Without the macro: ADC -> no le, done one cycle after accept, flags unchanged.
